// File: rtl/demux_router.sv
// demux_router: registered 1-to-CHANNELS demultiplexer with valid/ready on the
// input and on every output channel. Each channel owns a one-entry holding
// register, so a stalled consumer only blocks beats addressed to it.
//
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   In, Sel, Bcast      input beat, destination index, broadcast flag
//   In_valid/In_ready   input handshake (In_ready is combinational)
//   Out                 CHANNELS*WIDTH, channel k at [k*WIDTH +: WIDTH]
//   Out_valid/Out_ready per-channel handshake
//   Err_cnt             saturating count of dropped out-of-range beats

// One channel's holding register.
module demux_router_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             vld,
    output logic             free
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        // A load wins over a drain in the same cycle, so there is no bubble.
        if (load) begin
            data_d = din;
            vld_d  = 1'b1;
        end else if (vld_q && out_ready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign dout = data_q;
    assign vld  = vld_q;
    assign free = !vld_q || out_ready;
endmodule

module demux_router #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [WIDTH-1:0]          In,
    input  logic [SEL_W-1:0]          Sel,
    input  logic                      Bcast,
    input  logic                      In_valid,
    output logic                      In_ready,
    output logic [CHANNELS*WIDTH-1:0] Out,
    output logic [CHANNELS-1:0]       Out_valid,
    input  logic [CHANNELS-1:0]       Out_ready,
    output logic [7:0]                Err_cnt
);
    logic [CHANNELS-1:0][WIDTH-1:0] out_arr;
    logic [CHANNELS-1:0]            free;
    logic [CHANNELS-1:0]            load;
    logic                           sel_oor;
    logic                           in_ready_c;
    logic                           accept;
    logic [7:0]                     err_cnt_q, err_cnt_d;

    // Out-of-range selects only exist when CHANNELS is not a power of two.
    generate
        if ((1 << SEL_W) == CHANNELS) begin : g_pow2
            assign sel_oor = 1'b0;
        end else begin : g_npow2
            assign sel_oor = (Sel >= SEL_W'(CHANNELS));
        end
    endgenerate

    // Readiness ignores In_valid; held low throughout reset.
    always_comb begin
        in_ready_c = 1'b0;
        if (Rst_n) begin
            if (Bcast)        in_ready_c = &free;
            else if (sel_oor) in_ready_c = 1'b1;
            else              in_ready_c = free[Sel];
        end
    end

    assign In_ready = in_ready_c;
    assign accept   = In_valid && in_ready_c;

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k++) begin : g_lane
            assign load[k] = accept && (Bcast || (!sel_oor && (Sel == SEL_W'(k))));

            demux_router_lane #(.WIDTH(WIDTH)) u_lane (
                .clk      (Clk),
                .rst_n    (Rst_n),
                .load     (load[k]),
                .din      (In),
                .out_ready(Out_ready[k]),
                .dout     (out_arr[k]),
                .vld      (Out_valid[k]),
                .free     (free[k])
            );
        end
    endgenerate

    // Packed layout puts channel k at [k*WIDTH +: WIDTH].
    assign Out = out_arr;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !Bcast && sel_oor && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign Err_cnt = err_cnt_q;
endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: a 4-channel instance for the main
// function and a 3-channel instance for out-of-range drops.
module tb_demux_router;
    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;

    // 4-channel DUT
    logic [31:0]  in4 = '0;
    logic [1:0]   sel4 = '0;
    logic         bcast4 = 1'b0;
    logic         valid4 = 1'b0;
    logic         ready4;
    logic [127:0] out4;
    logic [3:0]   ovld4;
    logic [3:0]   ordy4 = 4'hF;
    logic [7:0]   err4;

    // 3-channel DUT
    logic [31:0]  in3 = '0;
    logic [1:0]   sel3 = '0;
    logic         bcast3 = 1'b0;
    logic         valid3 = 1'b0;
    logic         ready3;
    logic [95:0]  out3;
    logic [2:0]   ovld3;
    logic [2:0]   ordy3 = 3'h7;
    logic [7:0]   err3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    demux_router #(.WIDTH(32), .CHANNELS(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .In(in4), .Sel(sel4), .Bcast(bcast4),
        .In_valid(valid4), .In_ready(ready4), .Out(out4), .Out_valid(ovld4),
        .Out_ready(ordy4), .Err_cnt(err4)
    );

    demux_router #(.WIDTH(32), .CHANNELS(3)) dut3 (
        .Clk(Clk), .Rst_n(Rst_n), .In(in3), .Sel(sel3), .Bcast(bcast3),
        .In_valid(valid3), .In_ready(ready3), .Out(out3), .Out_valid(ovld3),
        .Out_ready(ordy3), .Err_cnt(err3)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (ovld4 !== 4'h0) begin n_err++; $display("FAIL rst_ovld got %h exp 0", ovld4); end
        n_cmp++; if (out4 !== 128'h0) begin n_err++; $display("FAIL rst_out got %h exp 0", out4); end
        n_cmp++; if (err4 !== 8'h0) begin n_err++; $display("FAIL rst_err got %h exp 0", err4); end
        n_cmp++; if (ready4 !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b exp 0", ready4); end
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        n_cmp++; if (ready4 !== 1'b1) begin n_err++; $display("FAIL rel_ready got %b exp 1", ready4); end
    endtask

    task automatic test_unicast();
        logic [31:0] v;
        ordy4 = 4'hF; sel4 = 2'd2; bcast4 = 1'b0; valid4 = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            v = 32'h0200 + i;
            in4 = v;
            #1;
            n_cmp++; if (ready4 !== 1'b1) begin n_err++; $display("FAIL uni_ready[%0d] got %b exp 1", i, ready4); end
            step();
            n_cmp++; if (ovld4 !== 4'b0100) begin n_err++; $display("FAIL uni_ovld[%0d] got %b exp 0100", i, ovld4); end
            n_cmp++; if (out4[64 +: 32] !== v) begin n_err++; $display("FAIL uni_out2[%0d] got %h exp %h", i, out4[64 +: 32], v); end
            n_cmp++; if ({out4[96 +: 32], out4[0 +: 64]} !== 96'h0) begin n_err++; $display("FAIL uni_other[%0d] got %h exp 0", i, {out4[96 +: 32], out4[0 +: 64]}); end
        end
        valid4 = 1'b0;
        step();
        n_cmp++; if (ovld4 !== 4'b0000) begin n_err++; $display("FAIL uni_drain got %b exp 0000", ovld4); end
        n_cmp++; if (out4[64 +: 32] !== 32'h0205) begin n_err++; $display("FAIL uni_hold got %h exp 00000205", out4[64 +: 32]); end
    endtask

    task automatic test_backpressure();
        ordy4 = 4'b1101; sel4 = 2'd1; in4 = 32'h3F01; valid4 = 1'b1;
        step();
        n_cmp++; if (ovld4 !== 4'b0010) begin n_err++; $display("FAIL bp_fill got %b exp 0010", ovld4); end
        in4 = 32'h3F02;
        #1;
        n_cmp++; if (ready4 !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready got %b exp 0", ready4); end
        step();
        n_cmp++; if (out4[32 +: 32] !== 32'h3F01) begin n_err++; $display("FAIL bp_hold got %h exp 00003f01", out4[32 +: 32]); end
        sel4 = 2'd3; in4 = 32'hF001;
        #1;
        n_cmp++; if (ready4 !== 1'b1) begin n_err++; $display("FAIL bp_other_ready got %b exp 1", ready4); end
        step();
        n_cmp++; if (out4[96 +: 32] !== 32'hF001) begin n_err++; $display("FAIL bp_out3 got %h exp 0000f001", out4[96 +: 32]); end
        n_cmp++; if (ovld4 !== 4'b1010) begin n_err++; $display("FAIL bp_ovld got %b exp 1010", ovld4); end
        valid4 = 1'b0; ordy4 = 4'hF;
        step();
        n_cmp++; if (ovld4 !== 4'b0000) begin n_err++; $display("FAIL bp_drain got %b exp 0000", ovld4); end
    endtask

    task automatic test_full_throughput();
        ordy4 = 4'b1110; sel4 = 2'd0; in4 = 32'hA0; valid4 = 1'b1;
        step();
        n_cmp++; if (ovld4[0] !== 1'b1) begin n_err++; $display("FAIL ft_fill got %b exp 1", ovld4[0]); end
        ordy4 = 4'hF; in4 = 32'hA1;
        #1;
        n_cmp++; if (ready4 !== 1'b1) begin n_err++; $display("FAIL ft_ready got %b exp 1", ready4); end
        step();
        n_cmp++; if (ovld4 !== 4'b0001) begin n_err++; $display("FAIL ft_ovld got %b exp 0001", ovld4); end
        n_cmp++; if (out4[0 +: 32] !== 32'hA1) begin n_err++; $display("FAIL ft_out0 got %h exp 000000a1", out4[0 +: 32]); end
        valid4 = 1'b0;
        step();
        n_cmp++; if (ovld4 !== 4'b0000) begin n_err++; $display("FAIL ft_drain got %b exp 0000", ovld4); end
    endtask

    task automatic test_broadcast();
        ordy4 = 4'b1011; sel4 = 2'd2; in4 = 32'h2222; valid4 = 1'b1;
        step();
        bcast4 = 1'b1; in4 = 32'hFFFF;
        #1;
        n_cmp++; if (ready4 !== 1'b0) begin n_err++; $display("FAIL bc_stall_ready got %b exp 0", ready4); end
        step();
        n_cmp++; if (out4[64 +: 32] !== 32'h2222) begin n_err++; $display("FAIL bc_hold2 got %h exp 00002222", out4[64 +: 32]); end
        n_cmp++; if (out4[0 +: 32] !== 32'hA1) begin n_err++; $display("FAIL bc_hold0 got %h exp 000000a1", out4[0 +: 32]); end
        ordy4 = 4'hF;
        #1;
        n_cmp++; if (ready4 !== 1'b1) begin n_err++; $display("FAIL bc_ready got %b exp 1", ready4); end
        step();
        n_cmp++; if (out4 !== {4{32'hFFFF}}) begin n_err++; $display("FAIL bc_out got %h exp all 0000ffff", out4); end
        n_cmp++; if (ovld4 !== 4'hF) begin n_err++; $display("FAIL bc_ovld got %b exp 1111", ovld4); end
        valid4 = 1'b0; bcast4 = 1'b0;
        step();
        n_cmp++; if (ovld4 !== 4'h0) begin n_err++; $display("FAIL bc_drain got %b exp 0000", ovld4); end
    endtask

    task automatic test_oor();
        logic [7:0] exp_err;
        sel3 = 2'd3; in3 = 32'hDEAD; ordy3 = 3'h7; valid3 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in3 = 32'hDEAD0000 + i;
            #1;
            n_cmp++; if (ready3 !== 1'b1) begin n_err++; $display("FAIL oor_ready[%0d] got %b exp 1", i, ready3); end
            step();
            exp_err = (i + 1 >= 255) ? 8'hFF : 8'(i + 1);
            n_cmp++; if (err3 !== exp_err) begin n_err++; $display("FAIL oor_err[%0d] got %0d exp %0d", i, err3, exp_err); end
            n_cmp++; if ((out3 !== 96'h0) || (ovld3 !== 3'h0)) begin n_err++; $display("FAIL oor_out[%0d] got %h/%b exp 0/000", i, out3, ovld3); end
        end
        valid3 = 1'b0;
        step();
        n_cmp++; if (err3 !== 8'hFF) begin n_err++; $display("FAIL oor_sat got %0d exp 255", err3); end
    endtask

    task automatic test_reset_mid();
        ordy4 = 4'h0; bcast4 = 1'b0; valid4 = 1'b1;
        sel4 = 2'd0; in4 = 32'h11; step();
        sel4 = 2'd1; in4 = 32'h22; step();
        sel4 = 2'd3; in4 = 32'h33; step();
        sel4 = 2'd2; valid4 = 1'b0;
        n_cmp++; if (ovld4 !== 4'b1011) begin n_err++; $display("FAIL rm_pre got %b exp 1011", ovld4); end
        #2;
        Rst_n = 1'b0;
        #1;
        n_cmp++; if (ovld4 !== 4'h0) begin n_err++; $display("FAIL rm_ovld got %b exp 0000", ovld4); end
        n_cmp++; if (out4 !== 128'h0) begin n_err++; $display("FAIL rm_out got %h exp 0", out4); end
        n_cmp++; if (ready4 !== 1'b0) begin n_err++; $display("FAIL rm_ready got %b exp 0", ready4); end
        n_cmp++; if (err3 !== 8'h0) begin n_err++; $display("FAIL rm_err got %0d exp 0", err3); end
        @(negedge Clk);
        Rst_n = 1'b1;
        ordy4 = 4'hF; sel4 = 2'd1; in4 = 32'h77; valid4 = 1'b1;
        step();
        n_cmp++; if ((ovld4 !== 4'b0010) || (out4[32 +: 32] !== 32'h77)) begin n_err++; $display("FAIL rm_first got %b/%h exp 0010/00000077", ovld4, out4[32 +: 32]); end
        valid4 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_backpressure();
        test_full_throughput();
        test_broadcast();
        test_oor();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
